// File: rtl/mont_pe_seq_if.sv
`default_nettype none
// ============================================================
// Module   : mont_pe_seq_if
// Brief    : Operand/result bus between the Montgomery sequencer and one PE.
// Revision : 1.0 - initial release
// ============================================================
interface mont_pe_seq_if #(
  parameter int RADIX = 32
) ();
  logic [RADIX-1:0] pe_a;
  logic [RADIX-1:0] pe_b;
  logic [RADIX-1:0] pe_p;
  logic [RADIX-1:0] pe_m;
  logic [RADIX-1:0] pe_s;
  logic [RADIX:0]   pe_c;
  logic             pe_odd;
  logic [RADIX-1:0] pe_s_out;
  logic [RADIX:0]   pe_c_out;

  modport master (
    output pe_a, pe_b, pe_p, pe_m, pe_s, pe_c, pe_odd,
    input  pe_s_out, pe_c_out
  );

  modport slave (
    input  pe_a, pe_b, pe_p, pe_m, pe_s, pe_c, pe_odd,
    output pe_s_out, pe_c_out
  );
endinterface
`default_nettype wire

// File: rtl/mont_pe_seq.sv
`default_nettype none
// ============================================================
// Module   : mont_pe_seq
// Brief    : Word-serial Montgomery multiply sequencer driving one external PE.
// Revision : 1.0 - initial release
// ============================================================
module mont_pe_seq #(
  parameter int RADIX     = 32,
  parameter int NUM_WORDS = 12
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [NUM_WORDS*RADIX-1:0] opa_in,
  input  logic [NUM_WORDS*RADIX-1:0] opb_in,
  input  logic [NUM_WORDS*RADIX-1:0] prime_in,
  input  logic [RADIX-1:0]           nprime_in,
  output logic                       busy,
  output logic                       done,
  output logic [NUM_WORDS*RADIX-1:0] result_out,
  output logic                       res_ovf,
  mont_pe_seq_if.master              pe
);

  localparam int IW = $clog2(NUM_WORDS);
  localparam int CW = $clog2(NUM_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_F0   = 3'd1,
    S_X1   = 3'd2,
    S_X2   = 3'd3,
    S_F1   = 3'd4,
    S_W    = 3'd5,
    S_WB   = 3'd6
  } state_t;

  state_t                     state_q, state_d;
  logic [IW-1:0]              row_q, row_d;
  logic [CW-1:0]              col_q, col_d;
  logic                       wb_vld_q, wb_vld_d;
  logic [CW-1:0]              wb_idx_q, wb_idx_d;
  logic [CW-1:0]              wb_dst;
  logic [RADIX-1:0]           a_q [NUM_WORDS];
  logic [RADIX-1:0]           a_d [NUM_WORDS];
  logic [RADIX-1:0]           b_q [NUM_WORDS];
  logic [RADIX-1:0]           b_d [NUM_WORDS];
  logic [RADIX-1:0]           p_q [NUM_WORDS];
  logic [RADIX-1:0]           p_d [NUM_WORDS];
  logic [RADIX-1:0]           t_q [NUM_WORDS+1];
  logic [RADIX-1:0]           t_d [NUM_WORDS+1];
  logic [RADIX-1:0]           np_q, np_d;
  logic [RADIX-1:0]           m_q, m_d;
  logic                       done_q, done_d;
  logic                       ovf_q, ovf_d;
  logic [NUM_WORDS*RADIX-1:0] result_q, result_d;
  logic                       unused_c_msb;

  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign res_ovf      = ovf_q;
  assign result_out   = result_q;
  assign wb_dst       = wb_idx_q - CW'(1);
  assign unused_c_msb = pe.pe_c_out[RADIX];

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    wb_vld_d = 1'b0;
    wb_idx_d = col_q;
    np_d     = np_q;
    m_d      = m_q;
    done_d   = 1'b0;
    ovf_d    = ovf_q;
    result_d = result_q;
    for (int k = 0; k < NUM_WORDS; k++) begin
      a_d[k] = a_q[k];
      b_d[k] = b_q[k];
      p_d[k] = p_q[k];
    end
    for (int k = 0; k <= NUM_WORDS; k++) begin
      t_d[k] = t_q[k];
    end
    pe.pe_a   = '0;
    pe.pe_b   = '0;
    pe.pe_p   = '0;
    pe.pe_m   = '0;
    pe.pe_s   = '0;
    pe.pe_c   = '0;
    pe.pe_odd = 1'b0;

    // PE output of the previous W step lands one word lower; word 0 is always zero.
    if (wb_vld_q && (wb_idx_q != '0)) begin
      t_d[wb_dst] = pe.pe_s_out;
      if (wb_idx_q == CW'(NUM_WORDS)) begin
        t_d[NUM_WORDS] = pe.pe_c_out[RADIX-1:0];
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          for (int k = 0; k < NUM_WORDS; k++) begin
            a_d[k] = opa_in[k*RADIX +: RADIX];
            b_d[k] = opb_in[k*RADIX +: RADIX];
            p_d[k] = prime_in[k*RADIX +: RADIX];
          end
          for (int k = 0; k <= NUM_WORDS; k++) begin
            t_d[k] = '0;
          end
          np_d    = nprime_in;
          row_d   = '0;
          col_d   = '0;
          state_d = S_F0;
        end
      end
      S_F0: state_d = S_X1;
      S_X1: begin
        pe.pe_odd = 1'b1;
        pe.pe_a   = a_q[0];
        pe.pe_b   = b_q[row_q];
        pe.pe_s   = t_q[0];
        state_d   = S_X2;
      end
      S_X2: begin
        // PE feeds back u on s, so u*(n'-1) + u yields m_i in the low word.
        pe.pe_a = pe.pe_s_out;
        pe.pe_b = np_q - RADIX'(1);
        state_d = S_F1;
      end
      S_F1: begin
        m_d     = pe.pe_s_out;
        col_d   = '0;
        state_d = S_W;
      end
      S_W: begin
        pe.pe_odd = 1'b1;
        pe.pe_s   = t_q[col_q];
        wb_vld_d  = 1'b1;
        if (col_q == CW'(NUM_WORDS)) begin
          col_d = '0;
          if (row_q == IW'(NUM_WORDS - 1)) begin
            state_d = S_WB;
          end else begin
            row_d   = row_q + IW'(1);
            state_d = S_F0;
          end
        end else begin
          pe.pe_a = a_q[col_q[IW-1:0]];
          pe.pe_b = b_q[row_q];
          pe.pe_p = p_q[col_q[IW-1:0]];
          pe.pe_m = m_q;
          col_d   = col_q + CW'(1);
        end
      end
      S_WB: begin
        for (int k = 0; k < NUM_WORDS; k++) begin
          result_d[k*RADIX +: RADIX] = t_d[k];
        end
        ovf_d   = (t_d[NUM_WORDS] != '0);
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      row_q    <= '0;
      col_q    <= '0;
      wb_vld_q <= 1'b0;
      wb_idx_q <= '0;
      np_q     <= '0;
      m_q      <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      for (int k = 0; k < NUM_WORDS; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        p_q[k] <= '0;
      end
      for (int k = 0; k <= NUM_WORDS; k++) begin
        t_q[k] <= '0;
      end
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      wb_vld_q <= wb_vld_d;
      wb_idx_q <= wb_idx_d;
      np_q     <= np_d;
      m_q      <= m_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
      for (int k = 0; k < NUM_WORDS; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        p_q[k] <= p_d[k];
      end
      for (int k = 0; k <= NUM_WORDS; k++) begin
        t_q[k] <= t_d[k];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mont_pe_seq.sv
`default_nettype none
// ============================================================
// Module   : tb_mont_pe_seq
// Brief    : Self-checking bench for mont_pe_seq with a behavioural PE (RADIX=4, N=2).
// Revision : 1.0 - initial release
// ============================================================
module tb_mont_pe_seq;
  localparam int RADIX  = 4;
  localparam int NW     = 2;
  localparam int W      = NW * RADIX;
  localparam int P      = 32'h35;
  localparam int NPRIME = 3;
  localparam int MASK   = (1 << RADIX) - 1;
  localparam int ROWLEN = NW + 5;
  localparam int LAT    = NW * ROWLEN + 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start;
  logic [W-1:0]     opa_in, opb_in, prime_in;
  logic [RADIX-1:0] nprime_in;
  logic             busy, done, res_ovf;
  logic [W-1:0]     result_out;

  mont_pe_seq_if #(.RADIX(RADIX)) pe_if ();

  mont_pe_seq #(.RADIX(RADIX), .NUM_WORDS(NW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .opa_in     (opa_in),
    .opb_in     (opb_in),
    .prime_in   (prime_in),
    .nprime_in  (nprime_in),
    .busy       (busy),
    .done       (done),
    .result_out (result_out),
    .res_ovf    (res_ovf),
    .pe         (pe_if)
  );

  always #5 clk = ~clk;

  // Behavioural PE: odd selects the carry chain and s_in, else c_in and s feedback.
  logic [RADIX-1:0] pe_s_q;
  logic [RADIX:0]   pe_c_q;
  int unsigned      pe_sum;
  always_comb begin
    pe_sum = int'(pe_if.pe_a) * int'(pe_if.pe_b) + int'(pe_if.pe_p) * int'(pe_if.pe_m)
           + (pe_if.pe_odd ? int'(pe_c_q) : int'(pe_if.pe_c))
           + (pe_if.pe_odd ? int'(pe_if.pe_s) : int'(pe_s_q));
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pe_s_q <= '0;
      pe_c_q <= '0;
    end else begin
      pe_s_q <= pe_sum[RADIX-1:0];
      pe_c_q <= pe_sum[2*RADIX:RADIX];
    end
  end
  assign pe_if.pe_s_out = pe_s_q;
  assign pe_if.pe_c_out = pe_c_q;

  int n_checks = 0;
  int n_errors = 0;

  int unsigned cur_a, cur_b;
  int unsigned exp_tin [NW];
  int unsigned exp_u   [NW];
  int unsigned exp_m   [NW];
  int unsigned exp_r;
  bit          exp_ovf;

  typedef struct {
    int unsigned a;
    int unsigned b;
    int unsigned r;
    bit          ovf;
  } vec_t;
  vec_t vecs [3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int unsigned wd(input int unsigned v, input int j);
    return (v >> (RADIX * j)) & MASK;
  endfunction

  // Word-level Montgomery: T = (T + A*b_i + m_i*p) / 2^RADIX per row.
  task automatic ref_mont(input int unsigned a, input int unsigned b);
    int unsigned t;
    int unsigned bi;
    t = 0;
    for (int i = 0; i < NW; i++) begin
      bi         = wd(b, i);
      exp_tin[i] = t;
      exp_u[i]   = (wd(t, 0) + wd(a, 0) * bi) & MASK;
      exp_m[i]   = (exp_u[i] * NPRIME) & MASK;
      t          = (t + a * bi + exp_m[i] * P) >> RADIX;
    end
    exp_r   = t & ((1 << W) - 1);
    exp_ovf = (t >> W) != 0;
  endtask

  task automatic launch(input int unsigned a, input int unsigned b);
    cur_a = a;
    cur_b = b;
    ref_mont(a, b);
    opa_in    = W'(a);
    opb_in    = W'(b);
    prime_in  = W'(P);
    nprime_in = RADIX'(NPRIME);
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    opa_in    = W'($urandom);
    opb_in    = W'($urandom);
    prime_in  = W'($urandom);
    nprime_in = RADIX'($urandom);
  endtask

  task automatic trace_check(input int n);
    int r, pos, j, bi;
    r   = (n - 1) / ROWLEN;
    pos = (n - 1) % ROWLEN;
    bi  = wd(cur_b, r);
    if (pos == 0 || pos == 3) begin
      check("flush", 64'({pe_if.pe_odd, pe_if.pe_c, pe_if.pe_a, pe_if.pe_b, pe_if.pe_p,
                          pe_if.pe_m, pe_if.pe_s}), 64'(0));
    end else if (pos == 1) begin
      check("x1_bus", 64'({pe_if.pe_odd, pe_if.pe_a, pe_if.pe_b, pe_if.pe_s, pe_if.pe_p, pe_if.pe_m}),
            64'({1'b1, RADIX'(wd(cur_a, 0)), RADIX'(bi), RADIX'(wd(exp_tin[r], 0)),
                 RADIX'(0), RADIX'(0)}));
    end else if (pos == 2) begin
      check("x2_bus", 64'({pe_if.pe_odd, pe_if.pe_a, pe_if.pe_b, pe_if.pe_c, pe_if.pe_p, pe_if.pe_m}),
            64'({1'b0, RADIX'(exp_u[r]), RADIX'((NPRIME - 1) & MASK), (RADIX + 1)'(0),
                 RADIX'(0), RADIX'(0)}));
    end else begin
      j = pos - 4;
      if (j < NW) begin
        check("w_bus", 64'({pe_if.pe_odd, pe_if.pe_a, pe_if.pe_b, pe_if.pe_p, pe_if.pe_m, pe_if.pe_s}),
              64'({1'b1, RADIX'(wd(cur_a, j)), RADIX'(bi), RADIX'(wd(P, j)),
                   RADIX'(exp_m[r]), RADIX'(wd(exp_tin[r], j))}));
      end else begin
        check("wn_bus", 64'({pe_if.pe_odd, pe_if.pe_c, pe_if.pe_a, pe_if.pe_b, pe_if.pe_p,
                             pe_if.pe_m, pe_if.pe_s}),
              64'({1'b1, (RADIX + 1)'(0), RADIX'(0), RADIX'(0), RADIX'(0), RADIX'(0),
                   RADIX'(wd(exp_tin[r], NW))}));
      end
    end
  endtask

  // Called right after launch; returns at the negedge inside the done cycle.
  task automatic wait_done(input int unsigned exp_res, input bit exp_of, input int inject_at);
    bit seen;
    seen = 1'b0;
    for (int n = 1; n <= LAT + 8 && !seen; n++) begin
      @(negedge clk);
      if (n == inject_at) begin
        start  = 1'b1;
        opa_in = W'(8'h2C);
        opb_in = W'(8'h2C);
      end else begin
        start = 1'b0;
      end
      if (n <= NW * ROWLEN) trace_check(n);
      if (n < LAT) check("busy_high", 64'(busy), 64'(1));
      if (done) begin
        seen = 1'b1;
        check("done_latency", 64'(n), 64'(LAT));
        check("busy_low_at_done", 64'(busy), 64'(0));
        check("result", 64'(result_out), 64'(exp_res));
        check("res_ovf", 64'(res_ovf), 64'(exp_of));
        check("congruence", 64'((int'(result_out) * (1 << W)) % P), 64'((cur_a * cur_b) % P));
      end
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL done_timeout: got no done expected done after %0d cycles", LAT);
    end
  endtask

  initial begin
    bit          saw;
    int unsigned ra, rb;

    vecs[0] = '{a: 32'h01, b: 32'h01, r: 32'h2F, ovf: 1'b0};
    vecs[1] = '{a: 32'h2C, b: 32'h01, r: 32'h01, ovf: 1'b0};
    vecs[2] = '{a: 32'h00, b: 32'h2C, r: 32'h00, ovf: 1'b0};

    reset_n   = 1'b0;
    start     = 1'b0;
    opa_in    = '0;
    opb_in    = '0;
    prime_in  = '0;
    nprime_in = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_result", 64'({res_ovf, result_out}), 64'(0));
    check("reset_pe_bus", 64'({pe_if.pe_odd, pe_if.pe_c, pe_if.pe_a, pe_if.pe_b, pe_if.pe_p,
                               pe_if.pe_m, pe_if.pe_s}), 64'(0));

    for (int v = 0; v < 3; v++) begin
      launch(vecs[v].a, vecs[v].b);
      wait_done(vecs[v].r, vecs[v].ovf, 0);
      @(negedge clk);
      check("done_one_cycle", 64'(done), 64'(0));
    end

    for (int v = 0; v < 12; v++) begin
      ra = $urandom_range(2 * P - 1);
      rb = $urandom_range(2 * P - 1);
      launch(ra, rb);
      wait_done(exp_r, exp_ovf, 0);
      @(negedge clk);
      check("done_one_cycle", 64'(done), 64'(0));
    end

    // Start pulsed mid-operation is ignored; start in the done cycle is accepted.
    launch(32'h01, 32'h01);
    wait_done(32'h2F, 1'b0, 5);
    launch(32'h2C, 32'h01);
    wait_done(32'h01, 1'b0, 0);

    // Asynchronous reset in cycle 9 aborts the operation.
    @(negedge clk);
    launch(32'h01, 32'h01);
    repeat (8) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_result", 64'({res_ovf, result_out}), 64'(0));
    check("abort_pe_odd", 64'(pe_if.pe_odd), 64'(0));
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    saw = 1'b0;
    for (int n = 0; n < LAT + 4; n++) begin
      @(negedge clk);
      if (done || busy) saw = 1'b1;
    end
    check("no_done_after_abort", 64'(saw), 64'(0));
    launch(32'h2C, 32'h01);
    wait_done(32'h01, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
